// File: rtl/pnc_gen_if.sv
// Handshake bundle for pnc_gen: sigma2 sample stream in, Kf result stream out.
interface pnc_gen_if #(
   parameter int unsigned DW    = 12,
   parameter int unsigned OW    = 12,
   parameter int unsigned CNT_W = 10
);
   logic [DW-1:0]    di;
   logic             di_vld;
   logic             di_sof;
   logic             di_rdy;
   logic [OW-1:0]    dout;
   logic             do_vld;
   logic [CNT_W-1:0] do_idx;
   logic             do_last;
   logic             div0;

   modport master (output di, di_vld, di_sof,
                   input  di_rdy, dout, do_vld, do_idx, do_last, div0);
   modport slave  (input  di, di_vld, di_sof,
                   output di_rdy, dout, do_vld, do_idx, do_last, div0);
endinterface

// File: rtl/pnc_gen.sv
// Payload noise weight Kf = (NUM << FRAC) / sigma2 via a restoring divider, windowed by subcarrier index.
// Optional PNC_CACHE_EN: reuse the last result when the same divisor repeats.
module pnc_gen #(
   parameter int unsigned DW    = 12,
   parameter int unsigned OW    = 12,
   parameter int unsigned NW    = 16,
   parameter int unsigned NUM   = 1578,
   parameter int unsigned FRAC  = 0,
   parameter int unsigned CNT_W = 10,
   parameter int unsigned START = 16,
   parameter int unsigned END   = 495
) (
   input  logic     clk,
   input  logic     rst_n,
   pnc_gen_if.slave bus
);
   localparam int unsigned DVW  = NW + FRAC;
   localparam int unsigned SW   = $clog2(DVW + 1);
   localparam int unsigned CW   = (DVW > OW) ? DVW : OW;
   localparam int unsigned KMAX = (32'd1 << (OW - 1)) - 32'd1;
   localparam logic [DVW-1:0]   DIVIDEND = DVW'(NUM) << FRAC;
   localparam logic [CNT_W-1:0] IDX_MAX  = '1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [DW-1:0]    div_q, div_d;
   logic [DW-1:0]    rem_q, rem_d;
   logic [DVW-1:0]   quot_q, quot_d;
   logic [SW-1:0]    step_q, step_d;
   logic             rdy_q, rdy_d;
   logic [OW-1:0]    dout_q, dout_d;
   logic [CNT_W-1:0] oidx_q, oidx_d;
   logic             vld_q, vld_d;
   logic             last_q, last_d;
   logic             div0_q, div0_d;

   logic             accept_c, in_win_c, hit_c, div_zero_c;
   logic [CNT_W-1:0] nidx_c;
   logic [DW:0]      rem_sh_c;
   logic [OW-1:0]    kf_c;

`ifdef PNC_CACHE_EN
   logic             cvld_q, cvld_d;
   logic             hit_q, hit_d;
   logic             cdiv0_q, cdiv0_d;
   logic [DW-1:0]    cdiv_q, cdiv_d;
   logic [OW-1:0]    cres_q, cres_d;
`endif

   // Index tracking, window test, divider step operand and saturated result.
   always_comb begin
      accept_c   = bus.di_vld && rdy_q;
      nidx_c     = bus.di_sof ? '0 : ((idx_q == IDX_MAX) ? idx_q : idx_q + CNT_W'(1));
      in_win_c   = (32'(nidx_c) >= START) && (32'(nidx_c) <= END);
      rem_sh_c   = {rem_q, quot_q[DVW-1]};
      div_zero_c = (div_q == '0);
      kf_c       = (div_zero_c || (CW'(quot_q) > CW'(KMAX))) ? OW'(KMAX) : OW'(quot_q);
`ifdef PNC_CACHE_EN
      hit_c      = cvld_q && (bus.di == cdiv_q);
`else
      hit_c      = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      div_d   = div_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      step_d  = step_q;
      dout_d  = dout_q;
      oidx_d  = oidx_q;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      div0_d  = 1'b0;
`ifdef PNC_CACHE_EN
      cvld_d  = cvld_q;
      hit_d   = hit_q;
      cdiv0_d = cdiv0_q;
      cdiv_d  = cdiv_q;
      cres_d  = cres_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               idx_d = nidx_c;
               if (in_win_c) begin
                  div_d   = bus.di;
                  rem_d   = '0;
                  quot_d  = DIVIDEND;
                  step_d  = '0;
                  state_d = hit_c ? DONE : CALC;
`ifdef PNC_CACHE_EN
                  hit_d   = hit_c;
`endif
               end
            end
         end
         // quot_q doubles as dividend shifter: MSB feeds the remainder, LSB takes the quotient bit.
         CALC: begin
            if (rem_sh_c >= {1'b0, div_q}) begin
               rem_d  = DW'(rem_sh_c - {1'b0, div_q});
               quot_d = {quot_q[DVW-2:0], 1'b1};
            end else begin
               rem_d  = DW'(rem_sh_c);
               quot_d = {quot_q[DVW-2:0], 1'b0};
            end
            step_d = step_q + SW'(1);
            if (step_q == SW'(DVW - 1)) state_d = DONE;
         end
         DONE: begin
            vld_d   = 1'b1;
            oidx_d  = idx_q;
            last_d  = (32'(idx_q) == END);
            dout_d  = kf_c;
            div0_d  = div_zero_c;
`ifdef PNC_CACHE_EN
            if (hit_q) begin
               dout_d = cres_q;
               div0_d = cdiv0_q;
            end else begin
               cvld_d  = 1'b1;
               cdiv_d  = div_q;
               cres_d  = kf_c;
               cdiv0_d = div_zero_c;
            end
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         step_q  <= '0;
         rdy_q   <= 1'b0;
         dout_q  <= '0;
         oidx_q  <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         step_q  <= step_d;
         rdy_q   <= rdy_d;
         dout_q  <= dout_d;
         oidx_q  <= oidx_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         div0_q  <= div0_d;
      end
   end

`ifdef PNC_CACHE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cvld_q  <= 1'b0;
         hit_q   <= 1'b0;
         cdiv0_q <= 1'b0;
         cdiv_q  <= '0;
         cres_q  <= '0;
      end else begin
         cvld_q  <= cvld_d;
         hit_q   <= hit_d;
         cdiv0_q <= cdiv0_d;
         cdiv_q  <= cdiv_d;
         cres_q  <= cres_d;
      end
   end
`endif

   assign bus.di_rdy  = rdy_q;
   assign bus.dout    = dout_q;
   assign bus.do_vld  = vld_q;
   assign bus.do_idx  = oidx_q;
   assign bus.do_last = last_q;
   assign bus.div0    = div0_q;
endmodule

// File: doc/pnc_gen.md
Name: pnc_gen

Overview:
Parametrised payload noise calculation block. Converts each per-subcarrier noise variance sigma2 into the fixed-point weight Kf = (NUM << FRAC) / sigma2 using an in-house iterative restoring divider with a valid/ready handshake. Forwards only the subcarriers inside a programmable index window. Sits between the noise estimator and the soft-demapper weighting stage; replaces the fixed-width, IP-divider noise calculator.

Parameters:
DW, 12, input sigma2 width (unsigned)
OW, 12, output Kf width (signed two's complement, always non-negative)
NW, 16, numerator width
NUM, 1578, numerator constant (payload subcarrier count)
FRAC, 0, fractional bits appended to the quotient
CNT_W, 10, subcarrier index counter width
START, 16, first in-window index (inclusive)
END, 495, last in-window index (inclusive)

Ports:
clk  in  1  working clock
rst_n  in  1  asynchronous reset, active low
di  in  DW  sigma2 sample, unsigned
di_vld  in  1  input valid
di_sof  in  1  first sample of a symbol; qualified by di_vld
di_rdy  out  1  block can accept a sample
do  out  OW  Kf result
do_vld  out  1  one-cycle result strobe
do_idx  out  CNT_W  subcarrier index of do
do_last  out  1  high with do_vld when do_idx == END
div0  out  1  one-cycle pulse with do_vld when di was 0

Behaviour:
- Reset (rst_n low, async): do, do_idx = 0; do_vld, do_last, div0 = 0; di_rdy = 0 while rst_n is low, 1 on the first clock after release; state = IDLE; index counter = 0; cache invalid.
- Accept = di_vld && di_rdy on a rising edge (edge E0).
- Index: an accepted sample with di_sof gets index 0. Otherwise it gets previous index + 1, saturating at 2^CNT_W - 1 (no wrap).
- States: IDLE, CALC, DONE.
- IDLE: di_rdy = 1.
  - Accepted in-window sample (START <= idx <= END): latch divisor and idx, go to CALC.
  - Accepted out-of-window sample: consumed, no output, stay IDLE (one per cycle).
- CALC: di_rdy = 0. Dividend = NUM << FRAC, width NW + FRAC. Restoring algorithm, one quotient bit per edge, MSB first. Lasts exactly NW + FRAC edges (E1..E(NW+FRAC)), then go to DONE.
- DONE: registers outputs on the next edge, returns to IDLE.
  - do_vld, do, do_idx, do_last, div0 become visible after edge E(NW+FRAC+1). Latency = NW + FRAC + 1 cycles; 17 at defaults.
  - di_rdy returns high after that same edge.
  - do_vld is one cycle. do and do_idx hold until the next result.
- Saturation:
  - Quotient > 2^(OW-1) - 1 gives do = 2^(OW-1) - 1.
  - di == 0 gives do = 2^(OW-1) - 1 with div0 = 1. The divider still runs, so latency is unchanged.
- di_sof while CALC is active: ignored, because di_rdy = 0 and the sample is not accepted. The upstream block must hold the sample.
- rst_n asserted mid-CALC: the division is aborted, no result is produced, and all outputs return to their reset values.

Optional Feature:
PNC_CACHE_EN
- Defined:
  - Holds last divisor and result, plus a valid flag cleared only by reset.
  - In-window sample with di equal to the cached divisor skips CALC. Outputs (stored result, its div0, new idx) appear after edge E1; di_rdy is high again after E1.
  - Any other in-window sample runs the full division and updates the cache on DONE.
- Undefined: no cache logic; every in-window sample takes NW + FRAC + 1 cycles.

Test Plan:
1. Defaults; di_sof with idx 0 then in-window di = 100 at idx 16 -> do = 15, do_idx = 16, do_vld exactly 17 cycles after accept, div0 = 0.
2. Defaults; in-window di = 1 -> do = 1578. In-window di = 0 -> do = 2047 with div0 = 1. With NUM = 4000, di = 1 -> do = 2047 (saturated), div0 = 0.
3. FRAC = 2; in-window di = 100 -> do = 63 (6312/100), latency 19 cycles.
4. Defaults; 512 samples di = 200 after di_sof, di_vld held high -> exactly 480 do_vld pulses, do = 7, do_idx 16..495, do_last only at 495; indices 0..15 and 496..511 consumed at one per cycle. A second di_sof restarts at index 0.
5. Defaults; assert rst_n low 5 cycles into CALC, release, then send di_sof with di = 50 followed by 16 samples so di = 50 lands at idx 16 -> no stale do_vld; final result do = 31 at idx 16.
6. PNC_CACHE_EN; in-window di = 100 twice back-to-back -> first result after 17 cycles, second after 1 cycle, both do = 15. Then di = 101 -> do = 15 after 17 cycles (full division).
